ddr_rw_arbiter: RTL

- Sits between the host-side read and write request queues and the DDR command sequencer.
- Selects which request issues next, batches same-direction traffic and enforces read/write bus turnaround gaps.
- Stops granting when the controller withdraws rw_proc, and reports rw_idle once all issued commands have completed. The controller needs rw_idle before it may refresh or update mode registers.

---
 rtl/ddr_rw_arbiter_pkg.sv | 17 +
 rtl/ddr_arb_timer.sv | 27 ++
 rtl/ddr_rw_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ddr_rw_arbiter_pkg.sv
// Shared types and DDR timing defaults for the read/write request arbiter.
package ddr_rw_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_TURN  = 2'd3
  } arb_state_type;

  localparam int DDR_T_RCD   = 11;
  localparam int DDR_T_RP    = 11;
  localparam int DDR_T_RTW   = 4;
  localparam int DDR_T_WTR   = 6;
  localparam int ARB_TIMER_W = 8;

endpackage

// File: rtl/ddr_arb_timer.sv
// Loadable down-counter for bus turnaround; done while the count is at or below one.
module ddr_arb_timer
  import ddr_rw_arbiter_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic [ARB_TIMER_W-1:0] i_load_val,
  output logic                   o_done
);

  logic [ARB_TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count <= ARB_TIMER_W'(1));

endmodule

// File: rtl/ddr_rw_arbiter.sv
// Read/write request arbiter: batches same-direction grants, inserts turnaround gaps,
// caps commands in flight and reports idle to the DDR controller.
module ddr_rw_arbiter
  import ddr_rw_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_MAX  = 4,
  parameter int T_RTW      = DDR_T_RTW,
  parameter int T_WTR      = DDR_T_WTR,
  parameter int MAX_OUT    = 8,
  localparam int OW        = $clog2(MAX_OUT + 1),
  localparam int SW        = $clog2(BURST_MAX + 1)
) (
  input  logic                  clock_t,
  input  logic                  reset_n,
  input  logic                  rw_proc,
  output logic                  rw_idle,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_ready,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic                  wr_req_ready,
  output logic                  cmd_valid,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_ready,
  input  logic                  cmd_done,
  output logic [OW-1:0]         outstanding
);

  arb_state_type r_state, w_state_nxt;
  logic                   r_dir;
  logic [SW-1:0]          r_streak;
  logic [OW-1:0]          r_outstanding, w_out_nxt;
  logic                   r_cmd_valid, r_cmd_write, r_rw_idle;
  logic [ADDR_WIDTH-1:0]  r_cmd_addr;

  logic w_cur_vld, w_oth_vld, w_burst_full, w_burst_last, w_slot, w_room, w_accept;
  logic w_can_grant, w_grant_rd, w_grant_wr, w_grant, w_switch, w_idle_dir;
  logic w_timer_load, w_turn_done, w_cmd_valid_nxt;
  logic [ARB_TIMER_W-1:0] w_turn_val;
  logic [OW:0]            w_occ;

  assign w_cur_vld    = r_dir ? wr_req_valid : rd_req_valid;
  assign w_oth_vld    = r_dir ? rd_req_valid : wr_req_valid;
  assign w_burst_full = (r_streak == SW'(BURST_MAX));
  assign w_burst_last = (r_streak == SW'(BURST_MAX - 1));
  assign w_slot       = !r_cmd_valid || cmd_ready;
  assign w_accept     = r_cmd_valid && cmd_ready;
  assign w_idle_dir   = !rd_req_valid;
  // A held command counts against the cap whether or not it is accepted this cycle.
  assign w_occ        = {1'b0, r_outstanding} + (OW + 1)'(r_cmd_valid);
  assign w_room       = (w_occ < (OW + 1)'(MAX_OUT));
  assign w_grant      = w_grant_rd || w_grant_wr;

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rw_proc) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_switch) w_state_nxt = ARB_TURN;
          else if (rd_req_valid || wr_req_valid) w_state_nxt = r_dir ? ARB_WRITE : ARB_READ;
        end
        ARB_READ, ARB_WRITE: begin
          if (w_switch) w_state_nxt = ARB_TURN;
          else if (!rd_req_valid && !wr_req_valid) w_state_nxt = ARB_IDLE;
        end
        default: begin
          if (w_turn_done) w_state_nxt = r_dir ? ARB_WRITE : ARB_READ;
        end
      endcase
    end
  end

  // The burst limit switches on the grant that fills it, so the gap is exactly the turnaround.
  always_comb begin
    w_can_grant = 1'b0;
    w_switch    = 1'b0;
    case (r_state)
      ARB_READ, ARB_WRITE: begin
        w_can_grant = rw_proc && w_cur_vld && !(w_burst_full && w_oth_vld) && w_slot && w_room;
        w_switch    = w_oth_vld && (!w_cur_vld || w_burst_full || (w_burst_last && w_can_grant));
      end
      ARB_IDLE: w_switch = (rd_req_valid || wr_req_valid) && (w_idle_dir != r_dir);
      default: ;
    endcase
    w_grant_rd   = w_can_grant && !r_dir;
    w_grant_wr   = w_can_grant && r_dir;
    w_timer_load = rw_proc && w_switch;
    w_turn_val   = r_dir ? ARB_TIMER_W'(T_WTR) : ARB_TIMER_W'(T_RTW);
  end

  ddr_arb_timer u_turn_timer (
    .i_clk      (clock_t),
    .i_rst_n    (reset_n),
    .i_en       (rw_proc),
    .i_load     (w_timer_load),
    .i_load_val (w_turn_val),
    .o_done     (w_turn_done)
  );

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      r_dir    <= 1'b0;
      r_streak <= '0;
    end else if (rw_proc) begin
      if (w_switch) begin
        r_dir    <= !r_dir;
        r_streak <= '0;
      end else if (w_state_nxt == ARB_IDLE) begin
        r_streak <= '0;
      end else if (w_grant && !w_burst_full) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_accept && !cmd_done) begin
      w_out_nxt = r_outstanding + 1'b1;
    end else if (!w_accept && cmd_done && (r_outstanding != '0)) begin
      w_out_nxt = r_outstanding - 1'b1;
    end
    w_cmd_valid_nxt = w_grant || (r_cmd_valid && !cmd_ready);
  end

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_write   <= 1'b0;
      r_cmd_addr    <= '0;
      r_outstanding <= '0;
      r_rw_idle     <= 1'b1;
    end else begin
      if (w_grant) begin
        r_cmd_valid <= 1'b1;
        r_cmd_write <= w_grant_wr;
        r_cmd_addr  <= w_grant_wr ? wr_req_addr : rd_req_addr;
      end else if (cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
      r_outstanding <= w_out_nxt;
      r_rw_idle     <= !w_cmd_valid_nxt && (w_out_nxt == '0);
    end
  end

  assign rd_req_ready = w_grant_rd;
  assign wr_req_ready = w_grant_wr;
  assign cmd_valid    = r_cmd_valid;
  assign cmd_write    = r_cmd_write;
  assign cmd_addr     = r_cmd_addr;
  assign outstanding  = r_outstanding;
  assign rw_idle      = r_rw_idle;

endmodule
